xbar_l2_req_issuer: RTL
=======================

XBAR_L2_REQ_ISSUER -- requirements
Module: xbar_l2_req_issuer

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  FIFO_DEPTH, 4, command FIFO entries (power of two, 2..16).
  MAX_OUTSTANDING, 2, granted requests awaiting r_valid (1..7).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  clk  in  1  single clock, all flops on posedge.
  rst  in  1  asynchronous, active-high reset.
  cmd_valid_i  in  1  core command valid.
  cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
  cmd_add_i  in  14  {row, bank} address.
  cmd_wen_i  in  1  0 = store, 1 = load.
  cmd_wdata_i  in  32  store data.
  cmd_be_i  in  4  byte enables.
  data_req_o  out  1  crossbar request.
  data_add_o  out  14  request address.
  data_wen_o  out  1  request wen.
  data_wdata_o  out  32  request write data.
  data_be_o  out  4  request byte enables.
  data_gnt_i  in  1  crossbar grant.
  data_r_valid_i  in  1  crossbar response valid (loads and stores).
  data_r_rdata_i  in  32  crossbar load data.
  rsp_valid_o  out  1  response to core.
  rsp_rdata_o  out  32  response data to core.
  busy_o  out  1  FSM not in IDLE.
  err_o  out  1  sticky protocol error (see Configuration).

Function
REQ-003 SHALL buffer commands in a FIFO: push on cmd_valid_i & cmd_ready_o; cmd_ready_o = !full, independent of same-cycle pop.
REQ-004 SHALL drive data_add/wen/wdata/be_o from the FIFO head; a command pushed into an empty FIFO is visible, with data_req_o high, no earlier than the next cycle.
REQ-005 SHALL keep data_req_o high and all data_*_o stable from assertion until the cycle data_gnt_i is sampled high; pop on data_req_o & data_gnt_i.
REQ-006 SHALL keep a 3-bit outstanding counter: +1 on req & gnt, -1 on data_r_valid_i; both in the same cycle leaves it unchanged.
REQ-007 SHALL deassert data_req_o whenever the registered counter equals MAX_OUTSTANDING, including a cycle in which data_r_valid_i is also high.
REQ-008 SHALL register responses: rsp_valid_o and rsp_rdata_o equal data_r_valid_i and data_r_rdata_i delayed one cycle; rsp_rdata_o holds its value when rsp_valid_o is low.
REQ-009 SHALL ignore data_r_valid_i when the counter is 0: no underflow and no rsp_valid_o pulse.
REQ-010 SHALL implement a 4-state FSM:
  IDLE: FIFO empty and counter 0.
  ISSUE: FIFO non-empty and counter < MAX_OUTSTANDING.
  STALL: FIFO non-empty and counter = MAX_OUTSTANDING.
  WAIT_RSP: FIFO empty and counter > 0.
  Next state is computed from the next FIFO occupancy and next counter value.
REQ-011 SHALL drive data_req_o high only in ISSUE.
REQ-012 SHALL produce responses in grant order; reordering is not supported.

Reset
REQ-013 SHALL, on rst high, asynchronously clear the FIFO pointers, the counter and err_o, and set the FSM to IDLE.
REQ-014 SHALL drive these values during reset: data_req_o=0, data_*_o=0, rsp_valid_o=0, rsp_rdata_o=0, busy_o=0, cmd_ready_o=1.
REQ-015 SHALL discard queued and outstanding transactions on reset mid-operation; responses arriving after reset release are ignored per REQ-009.

Configuration
REQ-016 SHALL, with XBAR_L2_ISSUER_ERR_EN defined, set err_o and hold it until reset on either condition:
  data_r_valid_i while the counter is 0;
  data_gnt_i while data_req_o is low.
REQ-017 SHALL, without XBAR_L2_ISSUER_ERR_EN, tie err_o to 0 and omit the error logic; all other behaviour is identical.

Verification
REQ-018 SHALL cover: single load of 0x0A5, gnt same cycle as req, r_valid next cycle with rdata 0xDEADBEEF -> data_req_o high 1 cycle, rsp_valid_o pulse 1 cycle after r_valid with rsp_rdata_o=0xDEADBEEF, busy_o back to 0.
REQ-019 SHALL cover: store with gnt held low 5 cycles -> data_req_o, data_add_o, data_wdata_o stable for all 6 cycles; exactly one pop.
REQ-020 SHALL cover: 5 back-to-back commands with gnt tied 0 and FIFO_DEPTH=4 -> cmd_ready_o low after the 4th push; the 5th is accepted the cycle after the first grant.
REQ-021 SHALL cover: MAX_OUTSTANDING=2, gnt always 1, r_valid withheld -> 2 grants then data_req_o low in STALL; a first r_valid re-enables req the following cycle.
REQ-022 SHALL cover: rst asserted with 3 queued and 2 outstanding -> outputs reach reset values immediately; a later r_valid produces no rsp_valid_o.
REQ-023 SHALL cover, with XBAR_L2_ISSUER_ERR_EN: r_valid while the counter is 0 -> err_o=1 next cycle and sticky; without the macro err_o stays 0.

Source files
------------

// File: rtl/xbar_l2_req_issuer.sv
//------------------------------------------------------------------------------
// Module   : xbar_l2_req_issuer
// Purpose  : Buffers core load/store commands in a small FIFO and issues them
//            to an L2 crossbar port with a req/gnt handshake, limiting the
//            number of granted-but-unanswered requests and registering the
//            in-order responses back to the core.
// Revision : 1.0 - initial release
//
// Parameters:
//   FIFO_DEPTH      - command FIFO entries (power of two, 2..16)
//   MAX_OUTSTANDING - granted requests awaiting r_valid (1..7)
//
// Ports:
//   clk, rst        - clock (posedge) and asynchronous active-high reset
//   cmd_*           - core command channel (valid/ready, addr, wen, wdata, be)
//   data_*_o        - crossbar request channel driven from the FIFO head
//   data_gnt_i      - crossbar grant
//   data_r_*_i      - crossbar response (valid, load data)
//   rsp_valid_o     - registered response valid to the core
//   rsp_rdata_o     - registered response data (held while rsp_valid_o low)
//   busy_o          - FSM not in IDLE
//   err_o           - sticky protocol error
//
// Build option:
//   XBAR_L2_ISSUER_ERR_EN - when defined, err_o latches on r_valid with no
//                           outstanding request or on gnt without req.
//                           When undefined, err_o is tied low.
//------------------------------------------------------------------------------
`default_nettype none

module xbar_l2_req_issuer #(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [13:0] cmd_add_i,
  input  logic        cmd_wen_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_be_i,
  output logic        data_req_o,
  output logic [13:0] data_add_o,
  output logic        data_wen_o,
  output logic [31:0] data_wdata_o,
  output logic [3:0]  data_be_o,
  input  logic        data_gnt_i,
  input  logic        data_r_valid_i,
  input  logic [31:0] data_r_rdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 14 + 1 + 32 + 4;

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [2:0]     MAX_C   = 3'(MAX_OUTSTANDING);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ISSUE    = 2'd1;
  localparam logic [1:0] S_STALL    = 2'd2;
  localparam logic [1:0] S_WAIT_RSP = 2'd3;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   fifo_cnt_q, fifo_cnt_d;
  logic [ENT_W-1:0] head;
  logic             fifo_full;
  logic             push;
  logic             pop;

  logic [2:0]       out_cnt_q, out_cnt_d;
  logic             rsp_inc;
  logic             rsp_dec;

  logic [1:0]       state_q, state_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;

  assign fifo_full   = (fifo_cnt_q == DEPTH_C);
  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign cmd_ready_o = ~fifo_full;
  assign push        = cmd_valid_i & ~fifo_full;
  // data_req_o is only high in ISSUE, which implies a non-empty FIFO.
  assign pop         = data_req_o & data_gnt_i;
  assign head        = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + (PTR_W+1)'(1);
    end else if (pop && !push) begin
      fifo_cnt_d = fifo_cnt_q - (PTR_W+1)'(1);
    end
  end

  // Storage is not reset: every output derived from it is gated by data_req_o.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_add_i, cmd_wen_i, cmd_wdata_i, cmd_be_i};
    end
  end

  // ---------------------------------------------------------------------------
  // Outstanding counter and response register
  // ---------------------------------------------------------------------------
  assign rsp_inc = pop;
  // A response with nothing outstanding is dropped: no underflow, no pulse.
  assign rsp_dec = data_r_valid_i & (out_cnt_q != 3'd0);

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (rsp_inc && !rsp_dec) begin
      out_cnt_d = out_cnt_q + 3'd1;
    end else if (rsp_dec && !rsp_inc) begin
      out_cnt_d = out_cnt_q - 3'd1;
    end
    rsp_valid_d = rsp_dec;
    rsp_rdata_d = rsp_dec ? data_r_rdata_i : rsp_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      out_cnt_q   <= 3'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      out_cnt_q   <= out_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;

  // ---------------------------------------------------------------------------
  // FSM: the state mirrors next-cycle occupancy/counter, so data_req_o comes
  // from a flop and drops in the same cycle the counter reaches the limit.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    if (fifo_cnt_d != '0) begin
      state_d = (out_cnt_d >= MAX_C) ? S_STALL : S_ISSUE;
    end else if (out_cnt_d != 3'd0) begin
      state_d = S_WAIT_RSP;
    end
  end

  always_comb begin
    data_req_o   = (state_q == S_ISSUE);
    busy_o       = (state_q != S_IDLE);
    data_add_o   = 14'd0;
    data_wen_o   = 1'b0;
    data_wdata_o = 32'd0;
    data_be_o    = 4'd0;
    if (data_req_o) begin
      {data_add_o, data_wen_o, data_wdata_o, data_be_o} = head;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky protocol error
  // ---------------------------------------------------------------------------
`ifdef XBAR_L2_ISSUER_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q
          | (data_r_valid_i & (out_cnt_q == 3'd0))
          | (data_gnt_i & ~data_req_o);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

`default_nettype wire
